// File: rtl/visca_pkg.sv
// Shared VISCA constants, sequencer state type and the command-table contents.
// The table function is the single source of truth for every command byte.
package visca_pkg;

    localparam logic [7:0] VISCA_TERM  = 8'hFF;
    localparam logic [7:0] VISCA_BCAST = 8'h88;
    localparam int unsigned MERGE_BIT  = 8;

    localparam int unsigned CMD_ZOOM_STOP    = 0;
    localparam int unsigned CMD_ZOOM_TELE    = 1;
    localparam int unsigned CMD_ZOOM_WIDE    = 2;
    localparam int unsigned CMD_FOCUS_AUTO   = 3;
    localparam int unsigned CMD_FOCUS_MANUAL = 4;
    localparam int unsigned CMD_POWER_ON     = 5;
    localparam int unsigned CMD_POWER_OFF    = 6;
    localparam int unsigned CMD_IF_CLEAR     = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } seq_state_e;

    // Entry = {MERGE, byte}; byte 0 holds a default header that the sequencer replaces with the camera address.
    function automatic logic [8:0] visca_entry(input int unsigned id, input int unsigned idx);
        logic [8:0] e;
        e = {1'b0, VISCA_TERM};
        if (id > CMD_IF_CLEAR) begin
            e = {1'b0, VISCA_TERM};
        end else begin
            case (idx)
                32'd0: e = 9'h081;
                32'd1: e = 9'h001;
                32'd2: e = (id == CMD_IF_CLEAR) ? 9'h000 : 9'h004;
                32'd3: begin
                    case (id)
                        CMD_ZOOM_STOP, CMD_ZOOM_TELE, CMD_ZOOM_WIDE: e = 9'h007;
                        CMD_FOCUS_AUTO, CMD_FOCUS_MANUAL:            e = 9'h038;
                        CMD_POWER_ON, CMD_POWER_OFF:                 e = 9'h000;
                        CMD_IF_CLEAR:                                e = 9'h001;
                        default:                                     e = {1'b0, VISCA_TERM};
                    endcase
                end
                32'd4: begin
                    case (id)
                        CMD_ZOOM_STOP:    e = 9'h000;
                        CMD_ZOOM_TELE:    e = 9'h120;
                        CMD_ZOOM_WIDE:    e = 9'h130;
                        CMD_FOCUS_AUTO:   e = 9'h002;
                        CMD_FOCUS_MANUAL: e = 9'h003;
                        CMD_POWER_ON:     e = 9'h002;
                        CMD_POWER_OFF:    e = 9'h003;
                        default:          e = {1'b0, VISCA_TERM};
                    endcase
                end
                default: e = {1'b0, VISCA_TERM};
            endcase
        end
        return e;
    endfunction

    function automatic logic [7:0] visca_merge(input logic [8:0] entry, input logic [3:0] param);
        logic [7:0] r;
        if (entry[MERGE_BIT]) begin
            r = {entry[7:4], param};
        end else begin
            r = entry[7:0];
        end
        return r;
    endfunction

    function automatic logic [7:0] visca_hdr(input logic [2:0] cam);
        logic [7:0] r;
        if (cam != 3'd0) begin
            r = {5'b10000, cam};
        end else begin
            r = VISCA_BCAST;
        end
        return r;
    endfunction

endpackage

// File: rtl/visca_cmd_seq_if.sv
// Command request and UART byte stream between control logic, sequencer and VISCA TX.
interface visca_cmd_seq_if #(
    parameter int unsigned IDW = 3
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [IDW-1:0] cmd_id;
    logic [3:0]     cmd_param;
    logic [2:0]     cam_addr;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           busy;
    logic           done;
    logic           err;

    modport master (
        output cmd_valid, cmd_id, cmd_param, cam_addr, tx_ready,
        input  cmd_ready, tx_data, tx_valid, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_id, cmd_param, cam_addr, tx_ready,
        output cmd_ready, tx_data, tx_valid, busy, done, err
    );
endinterface

// File: rtl/visca_cmd_rom.sv
// Command byte table with a registered read; address = {cmd_id, byte index}.
module visca_cmd_rom
    import visca_pkg::*;
#(
    parameter int unsigned NUM_CMD = 8,
    parameter int unsigned IDW     = 3,
    parameter int unsigned IW      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDW+IW-1:0] addr_i,
    output logic [8:0]        data_o
);
    logic [8:0] data_q;

    // Slots beyond the configured command count read as terminators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 9'h000;
        end else if (32'(addr_i[IDW+IW-1:IW]) < NUM_CMD) begin
            data_q <= visca_entry(32'(addr_i[IDW+IW-1:IW]), 32'(addr_i[IW-1:0]));
        end else begin
            data_q <= {1'b0, VISCA_TERM};
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/visca_cmd_seq.sv
// VISCA command sequencer: streams one table command per request to the UART TX,
// patching the camera address into byte 0 and merging the parameter nibble.
module visca_cmd_seq
    import visca_pkg::*;
#(
    parameter int unsigned NUM_CMD = 8,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    visca_cmd_seq_if.slave    bus
);
    localparam int unsigned IDW = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1;
    localparam int unsigned IW  = $clog2(MAX_LEN);

    seq_state_e     state_q;
    logic [IDW-1:0] id_q;
    logic [3:0]     param_q;
    logic [IW-1:0]  idx_q;
    logic           err_pend_q;
    logic [7:0]     tx_data_q;
    logic           tx_valid_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;
    logic           cmd_ready_q;

    logic [IDW-1:0] rom_id_d;
    logic [IW-1:0]  rom_idx_d;
    logic [8:0]     rom_entry_s;

    // The ROM runs one byte ahead so the following byte is ready on each handshake.
    always_comb begin
        rom_id_d  = id_q;
        rom_idx_d = idx_q + IW'(1);
        case (state_q)
            ST_IDLE: begin
                rom_id_d  = bus.cmd_id;
                rom_idx_d = IW'(1);
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    rom_idx_d = idx_q + IW'(2);
                end else begin
                    rom_idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                rom_id_d  = id_q;
                rom_idx_d = IW'(0);
            end
        endcase
    end

    visca_cmd_rom #(.NUM_CMD(NUM_CMD), .IDW(IDW), .IW(IW)) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_i ({rom_id_d, rom_idx_d}),
        .data_o (rom_entry_s)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            param_q     <= 4'h0;
            idx_q       <= '0;
            err_pend_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        id_q        <= bus.cmd_id;
                        param_q     <= bus.cmd_param;
                        idx_q       <= '0;
                        err_pend_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        if (32'(bus.cmd_id) >= NUM_CMD) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q    <= ST_SEND;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= visca_hdr(bus.cam_addr);
                        end
                    end
                end
                ST_SEND: begin
                    if (bus.tx_ready) begin
                        if (tx_data_q == VISCA_TERM) begin
                            tx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            err_q      <= err_pend_q;
                            state_q    <= ST_DONE;
                        end else if (idx_q == IW'(MAX_LEN - 2)) begin
                            // Table ran out of room without a terminator: close the frame.
                            tx_data_q  <= VISCA_TERM;
                            err_pend_q <= 1'b1;
                            idx_q      <= idx_q + IW'(1);
                        end else begin
                            tx_data_q <= visca_merge(rom_entry_s, param_q);
                            idx_q     <= idx_q + IW'(1);
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    tx_valid_q  <= 1'b0;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.cmd_ready = cmd_ready_q;
endmodule
